// File: rtl/adc_channel_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pkg_adc_regmap
// Brief    : Shared constants and sequencer state encoding for the ADC path.
// Revision : 1.0 - initial release
// ============================================================================
package pkg_adc_regmap;

    localparam int ADC_DEFAULT_PHASE_INC = 16;
    localparam int ADC_SETTLE_SAMPLES    = 32;

    typedef enum logic [2:0] {
        SEQ_IDLE        = 3'd0,
        SEQ_ISSUE       = 3'd1,
        SEQ_WAIT_ASSERT = 3'd2,
        SEQ_WAIT_REL    = 3'd3,
        SEQ_SETTLE      = 3'd4
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/adc_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : adc_sat_counter
// Brief    : Saturating up-counter with synchronous clear (clear wins).
// Revision : 1.0 - initial release
// ============================================================================
module adc_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    always_ff @(posedge i_clock) begin
        if (i_reset || i_clr) begin
            o_count <= '0;
        end else if (i_inc && (o_count != {WIDTH{1'b1}})) begin
            o_count <= o_count + WIDTH'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/adc_channel_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : adc_channel_sequencer
// Brief    : Retune sequencer for adc_dsp: phase update, optional soft reset,
//            local-reset tracking with timeout, and post-retune output blanking.
// Revision : 1.0 - initial release
// ============================================================================
module adc_channel_sequencer
    import pkg_adc_regmap::*;
#(
    parameter int PHASE_W           = 12,
    parameter int DEFAULT_PHASE_INC = ADC_DEFAULT_PHASE_INC,
    parameter int SETTLE_SAMPLES    = ADC_SETTLE_SAMPLES,
    parameter int RST_TIMEOUT       = 64,
    parameter int ERR_W             = 16
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_req_valid,
    output logic               o_req_ready,
    input  logic [PHASE_W-1:0] i_req_phase_inc,
    input  logic               i_req_flush,
    output logic               o_phase_inc_update,
    output logic [PHASE_W-1:0] o_phase_inc_new,
    output logic               o_sw_rst_strb,
    input  logic               i_local_rst_status,
    input  logic               i_dsp_valid,
    input  logic               i_flow_problem,
    output logic               o_gate,
    output logic               o_busy,
    output logic               o_done_strb,
    output logic               o_timeout_flag,
    input  logic               i_flow_err_clr,
    output logic [ERR_W-1:0]   o_flow_err_cnt
);

    localparam int c_SETTLE_W = $clog2(SETTLE_SAMPLES + 1);
    localparam int c_TMO_W    = $clog2(RST_TIMEOUT + 1);

    localparam logic [c_SETTLE_W-1:0] c_SETTLE_LAST = c_SETTLE_W'(SETTLE_SAMPLES - 1);
    localparam logic [c_TMO_W-1:0]    c_TMO_LAST    = c_TMO_W'(RST_TIMEOUT - 1);
    localparam logic [PHASE_W-1:0]    c_PHASE_RST   = PHASE_W'(DEFAULT_PHASE_INC);

    seq_state_t            r_state;
    logic                  r_flush;
    logic [c_SETTLE_W-1:0] r_settle_cnt;
    logic [c_TMO_W-1:0]    r_tmo_cnt;

    // Outputs are assigned on the same edge as the state change they belong to,
    // so every output is a flop and tracks r_state without extra latency.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state            <= SEQ_WAIT_REL;
            r_flush            <= 1'b0;
            r_settle_cnt       <= '0;
            r_tmo_cnt          <= '0;
            o_phase_inc_new    <= c_PHASE_RST;
            o_phase_inc_update <= 1'b0;
            o_sw_rst_strb      <= 1'b0;
            o_done_strb        <= 1'b0;
            o_timeout_flag     <= 1'b0;
            o_gate             <= 1'b0;
            o_busy             <= 1'b1;
            o_req_ready        <= 1'b0;
        end else begin
            o_phase_inc_update <= 1'b0;
            o_sw_rst_strb      <= 1'b0;
            o_done_strb        <= 1'b0;

            case (r_state)
                SEQ_IDLE: begin
                    if (i_req_valid) begin
                        o_phase_inc_new    <= i_req_phase_inc;
                        r_flush            <= i_req_flush;
                        o_phase_inc_update <= 1'b1;
                        o_sw_rst_strb      <= i_req_flush;
                        o_gate             <= 1'b0;
                        o_busy             <= 1'b1;
                        o_req_ready        <= 1'b0;
                        r_state            <= SEQ_ISSUE;
                    end
                end

                SEQ_ISSUE: begin
                    if (r_flush) begin
                        r_tmo_cnt <= '0;
                        r_state   <= SEQ_WAIT_ASSERT;
                    end else begin
                        r_settle_cnt <= '0;
                        r_state      <= SEQ_SETTLE;
                    end
                end

                SEQ_WAIT_ASSERT: begin
                    if (i_local_rst_status) begin
                        r_tmo_cnt <= '0;
                        r_state   <= SEQ_WAIT_REL;
                    end else if (r_tmo_cnt == c_TMO_LAST) begin
                        o_timeout_flag <= 1'b1;
                        r_settle_cnt   <= '0;
                        r_state        <= SEQ_SETTLE;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + c_TMO_W'(1);
                    end
                end

                SEQ_WAIT_REL: begin
                    if (!i_local_rst_status) begin
                        r_settle_cnt <= '0;
                        r_state      <= SEQ_SETTLE;
                    end else if (r_tmo_cnt == c_TMO_LAST) begin
                        o_timeout_flag <= 1'b1;
                        r_settle_cnt   <= '0;
                        r_state        <= SEQ_SETTLE;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + c_TMO_W'(1);
                    end
                end

                SEQ_SETTLE: begin
                    if (i_dsp_valid) begin
                        if (r_settle_cnt == c_SETTLE_LAST) begin
                            o_done_strb <= 1'b1;
                            o_gate      <= 1'b1;
                            o_busy      <= 1'b0;
                            o_req_ready <= 1'b1;
                            r_state     <= SEQ_IDLE;
                        end else begin
                            r_settle_cnt <= r_settle_cnt + c_SETTLE_W'(1);
                        end
                    end
                end

                default: begin
                    r_tmo_cnt   <= '0;
                    o_gate      <= 1'b0;
                    o_busy      <= 1'b1;
                    o_req_ready <= 1'b0;
                    r_state     <= SEQ_WAIT_REL;
                end
            endcase
        end
    end

    adc_sat_counter #(
        .WIDTH (ERR_W)
    ) u_flow_err_cnt (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_clr   (i_flow_err_clr),
        .i_inc   (i_flow_problem),
        .o_count (o_flow_err_cnt)
    );

endmodule
`default_nettype wire

// File: tb/tb_adc_channel_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_channel_sequencer
// Brief    : Directed self-checking bench for adc_channel_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adc_channel_sequencer;
    import pkg_adc_regmap::*;

    logic        i_clock = 1'b0;
    logic        i_reset;
    logic        i_req_valid;
    logic        o_req_ready;
    logic [11:0] i_req_phase_inc;
    logic        i_req_flush;
    logic        o_phase_inc_update;
    logic [11:0] o_phase_inc_new;
    logic        o_sw_rst_strb;
    logic        i_local_rst_status;
    logic        i_dsp_valid;
    logic        i_flow_problem;
    logic        o_gate;
    logic        o_busy;
    logic        o_done_strb;
    logic        o_timeout_flag;
    logic        i_flow_err_clr;
    logic [15:0] o_flow_err_cnt;

    int n_total = 0;
    int n_bad   = 0;

    always #5 i_clock = ~i_clock;

    adc_channel_sequencer dut (
        .i_clock            (i_clock),
        .i_reset            (i_reset),
        .i_req_valid        (i_req_valid),
        .o_req_ready        (o_req_ready),
        .i_req_phase_inc    (i_req_phase_inc),
        .i_req_flush        (i_req_flush),
        .o_phase_inc_update (o_phase_inc_update),
        .o_phase_inc_new    (o_phase_inc_new),
        .o_sw_rst_strb      (o_sw_rst_strb),
        .i_local_rst_status (i_local_rst_status),
        .i_dsp_valid        (i_dsp_valid),
        .i_flow_problem     (i_flow_problem),
        .o_gate             (o_gate),
        .o_busy             (o_busy),
        .o_done_strb        (o_done_strb),
        .o_timeout_flag     (o_timeout_flag),
        .i_flow_err_clr     (i_flow_err_clr),
        .o_flow_err_cnt     (o_flow_err_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clock);
        #1;
    endtask

    // Gate and done must stay low until the final beat, then rise together.
    task automatic run_beats(input int n);
        for (int i = 1; i <= n; i++) begin
            i_dsp_valid = 1'b1;
            tick();
            chk("beat_gate", 32'(o_gate),      32'(i == n));
            chk("beat_done", 32'(o_done_strb), 32'(i == n));
            chk("beat_rdy",  32'(o_req_ready), 32'(i == n));
        end
        i_dsp_valid = 1'b0;
    endtask

    task automatic request(input logic [11:0] ph, input logic fl);
        i_req_valid     = 1'b1;
        i_req_phase_inc = ph;
        i_req_flush     = fl;
        tick();
        i_req_valid     = 1'b0;
    endtask

    initial begin
        i_reset = 1'b1; i_req_valid = 1'b0; i_req_phase_inc = '0; i_req_flush = 1'b0;
        i_local_rst_status = 1'b0; i_dsp_valid = 1'b0; i_flow_problem = 1'b0; i_flow_err_clr = 1'b0;
        tick(); tick();
        chk("rst_gate",  32'(o_gate), 32'd0);
        chk("rst_busy",  32'(o_busy), 32'd1);
        chk("rst_ready", 32'(o_req_ready), 32'd0);
        chk("rst_phase", 32'(o_phase_inc_new), 32'd16);
        chk("rst_upd",   32'(o_phase_inc_update), 32'd0);
        chk("rst_sw",    32'(o_sw_rst_strb), 32'd0);
        chk("rst_done",  32'(o_done_strb), 32'd0);
        chk("rst_tmo",   32'(o_timeout_flag), 32'd0);
        chk("rst_cnt",   32'(o_flow_err_cnt), 32'd0);
        chk("rst_state", 32'(dut.r_state), 32'(SEQ_WAIT_REL));

        // Power-up: local reset held 15 cycles, then 32 beats
        i_reset = 1'b0; i_local_rst_status = 1'b1;
        repeat (15) tick();
        chk("pu_state", 32'(dut.r_state), 32'(SEQ_WAIT_REL));
        chk("pu_tmo",   32'(o_timeout_flag), 32'd0);
        i_local_rst_status = 1'b0;
        tick();
        chk("pu_settle", 32'(dut.r_state), 32'(SEQ_SETTLE));
        run_beats(32);
        chk("pu_busy", 32'(o_busy), 32'd0);
        tick();
        chk("pu_done_clr", 32'(o_done_strb), 32'd0);
        chk("pu_gate_hold", 32'(o_gate), 32'd1);

        // Plain retune; a beat during ISSUE must be dropped
        request(12'h123, 1'b0);
        chk("rt_upd",   32'(o_phase_inc_update), 32'd1);
        chk("rt_phase", 32'(o_phase_inc_new), 32'h123);
        chk("rt_sw",    32'(o_sw_rst_strb), 32'd0);
        chk("rt_gate",  32'(o_gate), 32'd0);
        chk("rt_ready", 32'(o_req_ready), 32'd0);
        chk("rt_state", 32'(dut.r_state), 32'(SEQ_ISSUE));
        i_dsp_valid = 1'b1;
        tick();
        i_dsp_valid = 1'b0;
        chk("rt_upd_clr", 32'(o_phase_inc_update), 32'd0);
        chk("rt_settle",  32'(dut.r_state), 32'(SEQ_SETTLE));
        run_beats(32);
        tick();

        // Flush retune with modelled adc_dsp local reset
        request(12'h2A5, 1'b1);
        chk("fl_upd",   32'(o_phase_inc_update), 32'd1);
        chk("fl_sw",    32'(o_sw_rst_strb), 32'd1);
        chk("fl_phase", 32'(o_phase_inc_new), 32'h2A5);
        tick();
        chk("fl_wa",     32'(dut.r_state), 32'(SEQ_WAIT_ASSERT));
        chk("fl_sw_clr", 32'(o_sw_rst_strb), 32'd0);
        tick();
        i_local_rst_status = 1'b1;
        tick();
        chk("fl_wr", 32'(dut.r_state), 32'(SEQ_WAIT_REL));
        i_dsp_valid = 1'b1;
        repeat (14) tick();
        i_dsp_valid = 1'b0;
        chk("fl_wr_hold", 32'(dut.r_state), 32'(SEQ_WAIT_REL));
        i_local_rst_status = 1'b0;
        tick();
        chk("fl_settle", 32'(dut.r_state), 32'(SEQ_SETTLE));
        chk("fl_tmo",    32'(o_timeout_flag), 32'd0);
        run_beats(32);
        tick();

        // Flush with local reset never asserting: timeout after 64 cycles
        request(12'h0F0, 1'b1);
        tick();
        chk("to_wa", 32'(dut.r_state), 32'(SEQ_WAIT_ASSERT));
        repeat (63) tick();
        chk("to_wa_hold", 32'(dut.r_state), 32'(SEQ_WAIT_ASSERT));
        chk("to_flag_lo", 32'(o_timeout_flag), 32'd0);
        tick();
        chk("to_settle",  32'(dut.r_state), 32'(SEQ_SETTLE));
        chk("to_flag_hi", 32'(o_timeout_flag), 32'd1);
        run_beats(32);
        tick();
        chk("to_sticky", 32'(o_timeout_flag), 32'd1);

        // Request held while busy: second accept on first IDLE cycle
        i_req_valid = 1'b1; i_req_phase_inc = 12'h055; i_req_flush = 1'b0;
        tick();
        chk("hb_phase1", 32'(o_phase_inc_new), 32'h055);
        chk("hb_upd1",   32'(o_phase_inc_update), 32'd1);
        i_req_phase_inc = 12'h0AA;
        tick();
        chk("hb_settle", 32'(dut.r_state), 32'(SEQ_SETTLE));
        chk("hb_phase_hold", 32'(o_phase_inc_new), 32'h055);
        chk("hb_upd_clr", 32'(o_phase_inc_update), 32'd0);
        run_beats(32);
        tick();
        chk("hb_upd2",   32'(o_phase_inc_update), 32'd1);
        chk("hb_phase2", 32'(o_phase_inc_new), 32'h0AA);
        chk("hb_ready2", 32'(o_req_ready), 32'd0);
        chk("hb_issue2", 32'(dut.r_state), 32'(SEQ_ISSUE));
        i_req_valid = 1'b0;
        tick();
        run_beats(32);
        tick();

        // Flow counter saturation and clear priority
        i_flow_problem = 1'b1;
        tick();
        chk("fc_one", 32'(o_flow_err_cnt), 32'd1);
        repeat (65540) tick();
        chk("fc_sat", 32'(o_flow_err_cnt), 32'hFFFF);
        i_flow_err_clr = 1'b1;
        tick();
        chk("fc_clr", 32'(o_flow_err_cnt), 32'd0);
        i_flow_err_clr = 1'b0;
        tick();
        chk("fc_inc", 32'(o_flow_err_cnt), 32'd1);
        i_flow_problem = 1'b0;
        tick();
        chk("fc_hold", 32'(o_flow_err_cnt), 32'd1);

        // Reset in the middle of a flush sequence
        request(12'h3FF, 1'b1);
        chk("mr_upd", 32'(o_phase_inc_update), 32'd1);
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        chk("mr_upd_clr", 32'(o_phase_inc_update), 32'd0);
        chk("mr_sw_clr",  32'(o_sw_rst_strb), 32'd0);
        chk("mr_phase",   32'(o_phase_inc_new), 32'd16);
        chk("mr_tmo",     32'(o_timeout_flag), 32'd0);
        chk("mr_cnt",     32'(o_flow_err_cnt), 32'd0);
        chk("mr_state",   32'(dut.r_state), 32'(SEQ_WAIT_REL));
        chk("mr_gate",    32'(o_gate), 32'd0);
        chk("mr_busy",    32'(o_busy), 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
